// File: rtl/write_combine_buffer.sv
// write_combine_buffer: packs DATA_WIDTH words into CACHE_WIDTH lines across NUM_SLOTS slots and issues CCI write requests
// ports: wr_req_* registered write request out (one per cycle), wr_rsp0/1_* write responses in,
//        in_* word/line/flush input channel gated by in_ready, wr_valid/flush_done pulses, outstanding count, idle
module write_combine_buffer #(
  parameter int ADDR_LMT = 20,
  parameter int MDATA = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS = 2,
  parameter int MAX_OUTSTANDING = 16,
  localparam int WORDS = CACHE_WIDTH / DATA_WIDTH,
  localparam int OFF_W = WORDS > 1 ? $clog2(WORDS) : 1,
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ADDR_LMT-1:0]       wr_req_addr,
  output logic [MDATA-1:0]          wr_req_mdata,
  output logic [CACHE_WIDTH-1:0]    wr_req_data,
  output logic                      wr_req_en,
  input  logic                      wr_req_almostfull,
  input  logic                      wr_rsp0_valid,
  input  logic [MDATA-1:0]          wr_rsp0_mdata,
  input  logic                      wr_rsp1_valid,
  input  logic [MDATA-1:0]          wr_rsp1_mdata,
  input  logic [ADDR_LMT+OFF_W-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [CACHE_WIDTH-1:0]    in_line,
  input  logic [MDATA-1:0]          in_mdata,
  input  logic                      in_en,
  input  logic                      in_direct,
  input  logic                      in_flush,
  output logic                      in_ready,
  output logic                      wr_valid,
  output logic                      wr_real_valid,
  output logic                      flush_done,
  output logic [OUT_W-1:0]          outstanding,
  output logic                      idle
);
  localparam int SW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
  localparam logic [SW-1:0] LAST = SW'(NUM_SLOTS - 1);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, state_d;
  logic [NUM_SLOTS-1:0] slot_valid;
  logic [ADDR_LMT-1:0] slot_line [NUM_SLOTS];
  logic [CACHE_WIDTH-1:0] slot_data [NUM_SLOTS];
  logic [WORDS-1:0] slot_mask [NUM_SLOTS];
  logic [MDATA-1:0] slot_mdata [NUM_SLOTS];
  logic [SW-1:0] victim, hit_idx, free_idx, drain_idx, tgt;
  logic hit, free, drain_any, drain_last, evict, full;
  logic can_issue, word_acc, drain_issue, issue, flush_fin;
  logic [ADDR_LMT-1:0] line_in, issue_addr;
  logic [OFF_W-1:0] off;
  logic [CACHE_WIDTH-1:0] merged, issue_data;
  logic [WORDS-1:0] new_mask;
  logic [MDATA-1:0] issue_mdata;
  logic [OUT_W:0] out_sum, rsp_cnt;
  logic [OUT_W-1:0] out_d;
  logic unused;
  assign line_in = in_addr[ADDR_LMT+OFF_W-1:OFF_W];
  assign off = in_addr[OFF_W-1:0];
  assign out_sum = {1'b0, outstanding} + (OUT_W+1)'(wr_req_en);
  assign rsp_cnt = (OUT_W+1)'(wr_rsp0_valid) + (OUT_W+1)'(wr_rsp1_valid);
  assign out_d = out_sum >= rsp_cnt ? OUT_W'(out_sum - rsp_cnt) : '0;
  // the request currently on wr_req_en is committed but not yet in outstanding, so it counts against the limit
  assign can_issue = !wr_req_almostfull && out_sum < (OUT_W+1)'(MAX_OUTSTANDING);
  assign in_ready = can_issue && state == IDLE;
  assign word_acc = in_ready && in_en && !in_direct;
  assign wr_real_valid = wr_rsp0_valid | wr_rsp1_valid;
  assign idle = slot_valid == '0 && outstanding == '0 && state == IDLE;
  assign unused = ^{wr_rsp0_mdata, wr_rsp1_mdata};
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    free = 1'b0;
    free_idx = '0;
    drain_any = 1'b0;
    drain_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_valid[i] && slot_line[i] == line_in) begin
        hit = 1'b1;
        hit_idx = SW'(i);
      end
      if (!slot_valid[i]) begin
        free = 1'b1;
        free_idx = SW'(i);
      end
      if (slot_valid[i]) begin
        drain_any = 1'b1;
        drain_idx = SW'(i);
      end
    end
    drain_last = (slot_valid & ~(NUM_SLOTS'(1) << drain_idx)) == '0;
    evict = !hit && !free;
    tgt = hit ? hit_idx : free ? free_idx : victim;
    merged = hit ? slot_data[tgt] : '0;
    merged[off*DATA_WIDTH +: DATA_WIDTH] = in_data;
    new_mask = (hit ? slot_mask[tgt] : '0) | (WORDS'(1) << off);
    full = &new_mask;
  end
  always_comb begin
    state_d = state;
    if (state == IDLE && in_ready && in_flush) state_d = DRAIN;
    else if (state == DRAIN && (!drain_any || (can_issue && drain_last))) state_d = IDLE;
  end
  always_comb begin
    drain_issue = state == DRAIN && can_issue && drain_any;
    flush_fin = state == DRAIN && state_d == IDLE;
    issue = drain_issue || (in_ready && in_direct) || (word_acc && (evict || full));
    issue_addr = drain_issue ? slot_line[drain_idx] : (!in_direct && evict) ? slot_line[victim] : line_in;
    issue_data = drain_issue ? slot_data[drain_idx] : in_direct ? in_line : evict ? slot_data[victim] : merged;
    issue_mdata = drain_issue ? slot_mdata[drain_idx] : in_direct ? in_mdata : evict ? slot_mdata[victim] :
                  hit ? slot_mdata[tgt] : in_mdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      victim <= '0;
      slot_valid <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_line[i] <= '0;
        slot_data[i] <= '0;
        slot_mask[i] <= '0;
        slot_mdata[i] <= '0;
      end
      wr_req_en <= 1'b0;
      wr_req_addr <= '0;
      wr_req_data <= '0;
      wr_req_mdata <= '0;
      wr_valid <= 1'b0;
      flush_done <= 1'b0;
      outstanding <= '0;
    end else begin
      state <= state_d;
      wr_req_en <= issue;
      wr_valid <= word_acc;
      flush_done <= flush_fin;
      outstanding <= out_d;
      if (issue) begin
        wr_req_addr <= issue_addr;
        wr_req_data <= issue_data;
        wr_req_mdata <= issue_mdata;
      end
      if (drain_issue) begin
        slot_valid[drain_idx] <= 1'b0;
        slot_mask[drain_idx] <= '0;
      end
      if (in_ready && in_direct)
        for (int i = 0; i < NUM_SLOTS; i++)
          if (slot_valid[i] && slot_line[i] == line_in) begin
            slot_valid[i] <= 1'b0;
            slot_mask[i] <= '0;
          end
      if (word_acc) begin
        slot_valid[tgt] <= !full;
        slot_line[tgt] <= line_in;
        slot_data[tgt] <= merged;
        slot_mask[tgt] <= full ? '0 : new_mask;
        if (!hit) slot_mdata[tgt] <= in_mdata;
        if (evict) victim <= victim == LAST ? '0 : victim + SW'(1);
      end
    end
  end
endmodule

// File: tb/tb_write_combine_buffer.sv
// tb_write_combine_buffer: directed scoreboard bench for write_combine_buffer
module tb_write_combine_buffer;
  localparam int AL = 20, MD = 14, CW = 512;
  logic clk = 1'b0, rst = 1'b1;
  logic [AL-1:0] wr_req_addr;
  logic [MD-1:0] wr_req_mdata, wr_rsp0_mdata, wr_rsp1_mdata, in_mdata;
  logic [CW-1:0] wr_req_data, in_line;
  logic wr_req_en, wr_req_almostfull, wr_rsp0_valid, wr_rsp1_valid;
  logic [AL+3:0] in_addr;
  logic [31:0] in_data;
  logic in_en, in_direct, in_flush, in_ready, wr_valid, wr_real_valid, flush_done, idle;
  logic [4:0] outstanding;
  always #5 clk = ~clk;
  write_combine_buffer dut (
    .clk(clk), .rst(rst), .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata), .wr_req_data(wr_req_data),
    .wr_req_en(wr_req_en), .wr_req_almostfull(wr_req_almostfull), .wr_rsp0_valid(wr_rsp0_valid),
    .wr_rsp0_mdata(wr_rsp0_mdata), .wr_rsp1_valid(wr_rsp1_valid), .wr_rsp1_mdata(wr_rsp1_mdata),
    .in_addr(in_addr), .in_data(in_data), .in_line(in_line), .in_mdata(in_mdata), .in_en(in_en),
    .in_direct(in_direct), .in_flush(in_flush), .in_ready(in_ready), .wr_valid(wr_valid),
    .wr_real_valid(wr_real_valid), .flush_done(flush_done), .outstanding(outstanding), .idle(idle)
  );
  typedef struct {logic [AL-1:0] a; logic [MD-1:0] m; logic [CW-1:0] d;} req_t;
  req_t q[$];
  int cmp = 0, mism = 0, nwv = 0, nfd = 0;
  task automatic chk(string n, logic [CW-1:0] act, logic [CW-1:0] exp);
    cmp++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic push(logic [AL-1:0] a, logic [MD-1:0] m, logic [CW-1:0] d);
    req_t r;
    r.a = a;
    r.m = m;
    r.d = d;
    q.push_back(r);
  endtask
  function automatic logic [CW-1:0] wl(int o, logic [31:0] v);
    logic [CW-1:0] r;
    r = '0;
    r[o*32 +: 32] = v;
    return r;
  endfunction
  always @(negedge clk) begin : monitor
    req_t e;
    if (wr_valid) nwv++;
    if (flush_done) nfd++;
    if (wr_req_en) begin
      if (q.size() == 0) begin
        cmp++;
        mism++;
        $display("FAIL unexpected_req: got addr %0h mdata %0h, expected no request", wr_req_addr, wr_req_mdata);
      end else begin
        e = q.pop_front();
        chk("req_addr", CW'(wr_req_addr), CW'(e.a));
        chk("req_mdata", CW'(wr_req_mdata), CW'(e.m));
        chk("req_data", wr_req_data, e.d);
      end
    end
  end
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_acc(string n);
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      cmp++;
      mism++;
      $display("FAIL %s: in_ready got 0 for 100 cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic word(logic [AL-1:0] l, logic [3:0] o, logic [31:0] d, logic [MD-1:0] m);
    in_addr = {l, o};
    in_data = d;
    in_mdata = m;
    in_en = 1'b1;
    wait_acc("word_accept");
    in_en = 1'b0;
  endtask
  task automatic direct(logic [AL-1:0] l, logic [CW-1:0] d, logic [MD-1:0] m);
    in_addr = {l, 4'h0};
    in_line = d;
    in_mdata = m;
    in_direct = 1'b1;
    wait_acc("direct_accept");
    in_direct = 1'b0;
  endtask
  task automatic flush();
    in_flush = 1'b1;
    wait_acc("flush_accept");
    in_flush = 1'b0;
  endtask
  task automatic rsp(logic a, logic b);
    wr_rsp0_valid = a;
    wr_rsp1_valid = b;
    cyc(1);
    wr_rsp0_valid = 1'b0;
    wr_rsp1_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
  initial begin
    logic [CW-1:0] exp;
    int v0, f0;
    {wr_req_almostfull, wr_rsp0_valid, wr_rsp1_valid, in_en, in_direct, in_flush} = '0;
    {wr_rsp0_mdata, wr_rsp1_mdata, in_mdata, in_addr, in_data, in_line} = '0;
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_en", CW'(wr_req_en), CW'(0));
    chk("rst_wr_valid", CW'(wr_valid), CW'(0));
    chk("rst_flush_done", CW'(flush_done), CW'(0));
    chk("rst_outstanding", CW'(outstanding), CW'(0));
    chk("rst_in_ready", CW'(in_ready), CW'(1));
    chk("rst_idle", CW'(idle), CW'(1));
    cyc(1);
    // full line assembled from 16 words
    exp = '0;
    for (int k = 0; k < 16; k++) exp[k*32 +: 32] = 32'(k + 1);
    push(20'h10, 14'h11, exp);
    v0 = nwv;
    for (int k = 0; k < 16; k++) word(20'h10, 4'(k), 32'(k + 1), 14'h11);
    @(negedge clk);
    chk("t1_issue_latency", CW'(wr_req_en), CW'(1));
    cyc(2);
    chk("t1_wr_valid_count", CW'(nwv - v0), CW'(16));
    rsp(1'b1, 1'b0);
    @(negedge clk);
    chk("t1_idle", CW'(idle), CW'(1));
    cyc(1);
    // eviction of the victim slot, victim pointer advancing
    push(20'h1, 14'h1, wl(3, 32'hA));
    word(20'h1, 4'd3, 32'hA, 14'h1);
    word(20'h2, 4'd3, 32'hB, 14'h2);
    word(20'h3, 4'd3, 32'hC, 14'h3);
    @(negedge clk);
    chk("t2_evict_latency", CW'(wr_req_en), CW'(1));
    push(20'h2, 14'h2, wl(3, 32'hB));
    word(20'h4, 4'd3, 32'hD, 14'h4);
    push(20'h3, 14'h3, wl(3, 32'hC));
    push(20'h4, 14'h4, wl(3, 32'hD));
    f0 = nfd;
    flush();
    cyc(4);
    chk("t2_flush_done", CW'(nfd - f0), CW'(1));
    rsp(1'b1, 1'b1);
    rsp(1'b1, 1'b1);
    @(negedge clk);
    chk("t2_outstanding", CW'(outstanding), CW'(0));
    cyc(1);
    // flush drains both slots on consecutive cycles
    push(20'h5, 14'h5, wl(0, 32'h55));
    push(20'h6, 14'h6, wl(1, 32'h66));
    word(20'h5, 4'd0, 32'h55, 14'h5);
    word(20'h6, 4'd1, 32'h66, 14'h6);
    flush();
    @(negedge clk);
    chk("t3_drain_c0_req", CW'(wr_req_en), CW'(0));
    @(negedge clk);
    chk("t3_drain_c1_req", CW'(wr_req_en), CW'(1));
    chk("t3_drain_c1_done", CW'(flush_done), CW'(0));
    @(negedge clk);
    chk("t3_drain_c2_req", CW'(wr_req_en), CW'(1));
    chk("t3_drain_c2_done", CW'(flush_done), CW'(1));
    cyc(1);
    rsp(1'b1, 1'b1);
    @(negedge clk);
    chk("t3_idle", CW'(idle), CW'(1));
    cyc(1);
    // direct write supersedes a buffered word on the same line
    v0 = nwv;
    push(20'h7, 14'h70, {16{32'hAAAAAAAA}});
    word(20'h7, 4'd2, 32'h77, 14'h7);
    direct(20'h7, {16{32'hAAAAAAAA}}, 14'h70);
    f0 = nfd;
    flush();
    cyc(4);
    chk("t4_flush_done", CW'(nfd - f0), CW'(1));
    chk("t4_wr_valid_count", CW'(nwv - v0), CW'(1));
    rsp(1'b1, 1'b0);
    @(negedge clk);
    chk("t4_idle", CW'(idle), CW'(1));
    cyc(1);
    // credit limit
    for (int i = 0; i < 16; i++) begin
      push(20'(32'h100 + i), 14'(i), {16{32'(i)}});
      direct(20'(32'h100 + i), {16{32'(i)}}, 14'(i));
    end
    cyc(3);
    @(negedge clk);
    chk("t5_outstanding_full", CW'(outstanding), CW'(16));
    chk("t5_ready_low", CW'(in_ready), CW'(0));
    cyc(1);
    rsp(1'b1, 1'b1);
    @(negedge clk);
    chk("t5_outstanding_dual", CW'(outstanding), CW'(14));
    chk("t5_ready_high", CW'(in_ready), CW'(1));
    cyc(1);
    repeat (7) rsp(1'b1, 1'b1);
    @(negedge clk);
    chk("t5_idle", CW'(idle), CW'(1));
    cyc(1);
    // link backpressure holds an evicting word
    word(20'h8, 4'd0, 32'h88, 14'h8);
    word(20'hA, 4'd0, 32'hA0, 14'hA);
    push(20'h8, 14'h8, wl(0, 32'h88));
    wr_req_almostfull = 1'b1;
    in_addr = {20'h9, 4'h0};
    in_data = 32'h99;
    in_mdata = 14'h9;
    in_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_ready_low", CW'(in_ready), CW'(0));
      chk("t6_no_req", CW'(wr_req_en), CW'(0));
    end
    cyc(1);
    wr_req_almostfull = 1'b0;
    wait_acc("t6_accept");
    in_en = 1'b0;
    @(negedge clk);
    chk("t6_issue_latency", CW'(wr_req_en), CW'(1));
    push(20'h9, 14'h9, wl(0, 32'h99));
    push(20'hA, 14'hA, wl(0, 32'hA0));
    flush();
    cyc(4);
    rsp(1'b1, 1'b1);
    rsp(1'b1, 1'b0);
    @(negedge clk);
    chk("t6_idle", CW'(idle), CW'(1));
    cyc(3);
    chk("sb_empty", CW'(q.size()), CW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule
